// File: rtl/chacha_deserialiser.sv
`default_nettype none
// ============================================================================
// Module      : chacha_deserialiser
// Description : Receive side of the ChaCha20 block word stream. Collects 16
//               serial words into a 4x4 word matrix and hands the complete
//               block to the consumer with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WORD_W         width of one serial word / matrix element
//   REVERSE_ORDER  1: word k -> [3-k[3:2]][3-k[1:0]]  (first word -> [3][3])
//                  0: word k -> [k[3:2]][k[1:0]]      (first word -> [0][0])
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   in_data     serial input word
//   in_valid    in_data is valid this cycle
//   in_ready    a word can be accepted this cycle (collecting)
//   flush       discard the partially collected block (ignored when full)
//   out_block   assembled 4x4 matrix
//   out_valid   out_block holds a complete block
//   out_ready   consumer takes out_block this cycle
//   word_count  words held in the current block, 0..16
// ============================================================================
module chacha_deserialiser #(
    parameter int WORD_W        = 32,
    parameter bit REVERSE_ORDER = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [3:0][3:0][WORD_W-1:0]   out_block,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4:0]                    word_count
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic [4:0]                    count_q;
    logic [4:0]                    count_d;
    logic [3:0][3:0][WORD_W-1:0]   block_q;

    logic                          wr_en;
    logic [3:0]                    wr_k;
    logic [1:0]                    wr_row;
    logic [1:0]                    wr_col;

    // Only the low four bits address the matrix; in FILL the count is 0..15.
    assign wr_k   = count_q[3:0];

    // For a 2-bit index, 3-x is simply the bitwise inverse.
    assign wr_row = REVERSE_ORDER ? ~wr_k[3:2] : wr_k[3:2];
    assign wr_col = REVERSE_ORDER ? ~wr_k[1:0] : wr_k[1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        case (state_q)
            S_FILL: begin
                // flush wins over a word presented in the same cycle
                if (flush) begin
                    count_d = '0;
                end else if (in_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 5'd1;
                    if (wr_k == 4'd15) begin
                        state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                // flush and in_valid are ignored: a finished block is kept
                // until the consumer takes it.
                if (out_ready) begin
                    state_d = S_FILL;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_FILL;
                count_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and matrix registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            count_q <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (wr_en) begin
                block_q[wr_row][wr_col] <= in_data;
            end
        end
    end

    // Handshake flags are pure state decodes: no input-to-output paths.
    assign in_ready   = (state_q == S_FILL);
    assign out_valid  = (state_q == S_FULL);
    assign out_block  = block_q;
    assign word_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_chacha_deserialiser.sv
`default_nettype none
// ============================================================================
// Module      : tb_chacha_deserialiser
// Description : Self-checking bench for chacha_deserialiser. Random word
//               streams are checked cycle by cycle against a behavioural
//               model, and delivered blocks against the source matrices.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chacha_deserialiser;

    localparam int C_W   = 32;
    localparam bit C_REV = 1'b1;

    logic                       clk;
    logic                       rst;
    logic [C_W-1:0]             in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       flush;
    logic [3:0][3:0][C_W-1:0]   out_block;
    logic                       out_valid;
    logic                       out_ready;
    logic [4:0]                 word_count;

    chacha_deserialiser #(
        .WORD_W        (C_W),
        .REVERSE_ORDER (C_REV)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_block  (out_block),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model state: number of held words, full flag, matrix as flat vector
    // where element [r][c] lives at bits (r*4+c)*32.
    int           m_cnt  = 0;
    bit           m_full = 1'b0;
    logic [511:0] m_mat  = '0;

    logic [C_W-1:0] pend[$];     // words waiting to be sent
    logic [511:0]   sb[$];       // expected blocks, in delivery order
    bit             from_q  = 1'b0;
    int             gap_cnt = 0;
    int             gap_max = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flat matrix index (row*4+col) that serial word k lands on.
    function automatic int pos(input int k);
        return C_REV ? 15 - k : k;
    endfunction

    // One clock: advance the model from the current inputs, then check the
    // DUT just after the edge.
    task automatic tick();
        bit           acc;
        logic [511:0] ob;
        acc = 1'b0;
        if (rst) begin
            m_cnt  = 0;
            m_full = 1'b0;
            m_mat  = '0;
        end else if (!m_full) begin
            if (flush) begin
                m_cnt = 0;
            end else if (in_valid) begin
                m_mat[pos(m_cnt)*32 +: 32] = in_data;
                m_cnt++;
                acc = 1'b1;
                if (m_cnt == 16) m_full = 1'b1;
            end
        end else if (out_ready) begin
            ob = out_block;
            if (sb.size() > 0) check("loopback", ob, sb.pop_front());
            m_full = 1'b0;
            m_cnt  = 0;
        end
        if (acc && from_q && pend.size() > 0) begin
            void'(pend.pop_front());
            gap_cnt = $urandom_range(gap_max, 0);
        end
        @(posedge clk);
        #1;
        ob = out_block;
        check("word_count", 512'(word_count), 512'(m_cnt));
        check("out_valid", 512'(out_valid), 512'(m_full));
        check("in_ready", 512'(in_ready), 512'(!m_full));
        check("block", ob, m_mat);
    endtask

    // Drive one cycle from the pending-word queue with random gaps and a
    // random out_ready (probability ready_pct %).
    task automatic feed(input int ready_pct);
        rst   = 1'b0;
        flush = 1'b0;
        if (pend.size() > 0 && gap_cnt == 0) begin
            in_valid = 1'b1;
            in_data  = pend[0];
            from_q   = 1'b1;
        end else begin
            if (gap_cnt > 0) gap_cnt--;
            in_valid = 1'b0;
            in_data  = $urandom;
            from_q   = 1'b0;
        end
        out_ready = ($urandom_range(99, 0) < ready_pct);
        tick();
    endtask

    task automatic push_words(input logic [C_W-1:0] w[16]);
        logic [511:0] exp;
        exp = '0;
        for (int k = 0; k < 16; k++) begin
            exp[pos(k)*32 +: 32] = w[k];
            pend.push_back(w[k]);
        end
        sb.push_back(exp);
    endtask

    // Random matrix serialised in the little-endian walk (first word is
    // element [3][3], last is [0][0]); the expected block is the matrix.
    task automatic send_matrix();
        logic [C_W-1:0] mat[4][4];
        logic [511:0]   exp;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mat[r][c] = $urandom;
                exp[(r*4+c)*32 +: 32] = mat[r][c];
            end
        for (int k = 0; k < 16; k++)
            pend.push_back(mat[3 - k/4][3 - k%4]);
        sb.push_back(exp);
    endtask

    task automatic fill_until_full();
        int n;
        n = 0;
        while (!m_full && n < 400) begin
            feed(0);
            n++;
        end
        if (!m_full) check("fill_timeout", 512'(0), 512'(1));
    endtask

    task automatic drain(input int ready_pct, input int budget);
        int n;
        n = 0;
        while ((sb.size() > 0 || pend.size() > 0) && n < budget) begin
            feed(ready_pct);
            n++;
        end
        if (sb.size() > 0 || pend.size() > 0) begin
            check("drain_timeout", 512'(sb.size()), 512'(0));
            sb.delete();
            pend.delete();
        end
    endtask

    initial begin
        logic [C_W-1:0] w[16];
        logic [511:0]   snap;
        int             n;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // T1: reset, then reset again in the middle of a fill
        tick();
        tick();
        for (int k = 0; k < 7; k++) pend.push_back(32'h1000 + k);
        gap_max = 0; gap_cnt = 0;
        n = 0;
        while (m_cnt < 7 && n < 50) begin feed(0); n++; end
        check("t1_mid_count", 512'(word_count), 512'(7));
        pend.delete();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; from_q = 1'b0;
        tick();
        tick();
        check("t1_rst_count", 512'(word_count), 512'(0));
        check("t1_rst_block", 512'(out_block), 512'(0));
        check("t1_rst_ready", 512'(in_ready), 512'(1));
        rst = 1'b0;

        // T2: ordering with words 0..15 back-to-back
        for (int k = 0; k < 16; k++) w[k] = k;
        push_words(w);
        fill_until_full();
        check("t2_e33", 512'(out_block[3][3]), 512'(32'h0));
        check("t2_e30", 512'(out_block[3][0]), 512'(32'h3));
        check("t2_e00", 512'(out_block[0][0]), 512'(32'hF));
        drain(100, 50);

        // T4: backpressure with in_valid held high
        for (int k = 0; k < 16; k++) w[k] = $urandom;
        push_words(w);
        fill_until_full();
        snap = out_block;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = $urandom; from_q = 1'b0; out_ready = 1'b0;
            tick();
        end
        check("t4_stable", 512'(out_block), snap);
        check("t4_count", 512'(word_count), 512'(16));
        check("t4_in_ready", 512'(in_ready), 512'(0));
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        check("t4_back_fill", 512'(in_ready), 512'(1));
        out_ready = 1'b0;

        // T5: flush mid-fill drops the concurrent word; flush when full is ignored
        for (int k = 0; k < 5; k++) pend.push_back(32'h5000 + k);
        n = 0;
        while (m_cnt < 5 && n < 50) begin feed(0); n++; end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; from_q = 1'b0; out_ready = 1'b0;
        tick();
        check("t5_flush_count", 512'(word_count), 512'(0));
        flush = 1'b0;
        for (int k = 0; k < 16; k++) w[k] = 32'hA0 + k;
        push_words(w);
        fill_until_full();
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        flush = 1'b0;
        check("t5_full_kept", 512'(out_valid), 512'(1));
        check("t5_e33", 512'(out_block[3][3]), 512'(32'hA0));
        check("t5_e00", 512'(out_block[0][0]), 512'(32'hAF));
        drain(100, 50);

        // T3: 100 random matrices back-to-back
        gap_max = 0;
        for (int b = 0; b < 100; b++) send_matrix();
        drain(100, 2500);

        // T6: random gaps of 0..5 cycles and random out_ready
        gap_max = 5;
        for (int b = 0; b < 30; b++) send_matrix();
        drain(50, 6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
